// File: rtl/spi_pkg.sv
// Shared types and mode constants for the parametrised SPI slave.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

  // SPI modes encoded as {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for a single asynchronous input bit.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave, clk-domain oversampled, any of the four modes, 1-entry tx holding buffer.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] IDLE_TX   = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int unsigned       CNT_W = $clog2(DATA_W);
  localparam logic [1:0]        MODE  = {CPOL, CPHA};
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

  logic cs_s, sclk_s, mosi_s;
  logic cs_d, sclk_d;
  logic [2:0] settle;

  spi_sync #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(cs),   .q(cs_s));
  spi_sync #(.RST_VAL(CPOL)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

  spi_state_t state, state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift, rx_shift, buf_data, ld_word, rx_next;
  logic buf_full, ld_from_empty;
  logic lead_edge, trail_edge, cs_fall, run, sample, shift, word_done, load, accept;

  function automatic logic out_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_d   <= 1'b1;
      sclk_d <= CPOL;
      settle <= '0;
    end else begin
      cs_d   <= cs_s;
      sclk_d <= sclk_s;
      settle <= {settle[1:0], 1'b1};
    end
  end

  // The synchroniser reset fill looks like a cs fall when cs is held low
  // across reset; edges are only trusted once that fill has drained.
  assign cs_fall    = settle[2] && cs_d && !cs_s;
  assign lead_edge  = (sclk_d == MODE[1]) && (sclk_s != MODE[1]);
  assign trail_edge = (sclk_d != MODE[1]) && (sclk_s == MODE[1]);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (cs_fall) state_next = ST_ACTIVE;
      ST_ACTIVE: if (cs_s)    state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // In CPHA=0 the trailing edge right after a word wrap must not shift:
  // the wrap load already put the new word's first bit on miso.
  assign run       = (state == ST_ACTIVE) && !cs_s;
  assign sample    = run && (MODE[0] ? trail_edge : lead_edge);
  assign shift     = run && (MODE[0] ? lead_edge : (trail_edge && (bit_cnt != '0)));
  assign word_done = sample && (bit_cnt == LAST);
  assign load      = ((state == ST_IDLE) && cs_fall) || word_done;
  assign accept    = tx_valid && !buf_full;
  assign ld_word   = buf_full ? buf_data : IDLE_TX;
  assign rx_next   = MSB_FIRST ? {rx_shift[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift[DATA_W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso          <= 1'b0;
      bit_cnt       <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      buf_data      <= '0;
      buf_full      <= 1'b0;
      ld_from_empty <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      tx_underrun   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (accept) buf_data <= tx_data;
      if (accept)    buf_full <= 1'b1;
      else if (load) buf_full <= 1'b0;

      if (load) begin
        ld_from_empty <= !buf_full;
        if (!MODE[0]) begin
          miso     <= out_bit(ld_word);
          tx_shift <= advance(ld_word);
        end else begin
          tx_shift <= ld_word;
        end
      end else if (shift) begin
        miso     <= out_bit(tx_shift);
        tx_shift <= advance(tx_shift);
      end

      // Underrun is flagged when a word built from IDLE_TX actually starts
      // clocking, so a trailing wrap load before cs release is harmless.
      if (sample) begin
        if ((bit_cnt == '0) && ld_from_empty) tx_underrun <= 1'b1;
        rx_shift <= rx_next;
        bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
      end
      if (word_done) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end

      if (state_next == ST_IDLE) begin
        miso    <= 1'b0;
        bit_cnt <= '0;
      end
    end
  end

  assign tx_ready = !buf_full;
  assign busy     = (state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench: mode 0 / mode 3 / 16-bit LSB-first instances driven by a behavioural SPI master.
`timescale 1ns/1ps
module tb_spi_slave_param;

  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] cs_v, sclk_v, mosi_v, txv_v;
  logic [7:0]  txd0, txd1;
  logic [15:0] txd2;
  logic miso0, miso1, miso2, txr0, txr1, txr2, rxv0, rxv1, rxv2;
  logic und0, und1, und2, busy0, busy1, busy2;
  logic [7:0]  rxd0, rxd1;
  logic [15:0] rxd2;
  int checks = 0, failures = 0;
  int rxc0 = 0, rxc1 = 0, rxc2 = 0;

  always #5 clk = ~clk;

  spi_slave_param u0 (
    .clk(clk), .rst_n(rst_n), .cs(cs_v[0]), .sclk(sclk_v[0]), .mosi(mosi_v[0]), .miso(miso0),
    .tx_data(txd0), .tx_valid(txv_v[0]), .tx_ready(txr0), .rx_data(rxd0), .rx_valid(rxv0),
    .tx_underrun(und0), .busy(busy0));

  spi_slave_param #(.CPOL(1'b1), .CPHA(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .cs(cs_v[1]), .sclk(sclk_v[1]), .mosi(mosi_v[1]), .miso(miso1),
    .tx_data(txd1), .tx_valid(txv_v[1]), .tx_ready(txr1), .rx_data(rxd1), .rx_valid(rxv1),
    .tx_underrun(und1), .busy(busy1));

  spi_slave_param #(.DATA_W(16), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .cs(cs_v[2]), .sclk(sclk_v[2]), .mosi(mosi_v[2]), .miso(miso2),
    .tx_data(txd2), .tx_valid(txv_v[2]), .tx_ready(txr2), .rx_data(rxd2), .rx_valid(rxv2),
    .tx_underrun(und2), .busy(busy2));

  always @(negedge clk) begin
    if (rxv0) rxc0++;
    if (rxv1) rxc1++;
    if (rxv2) rxc2++;
  end

  function automatic int cfg_w(input int k);     return (k == 2) ? 16 : 8; endfunction
  function automatic logic cfg_cpol(input int k); return k == 1; endfunction
  function automatic logic cfg_cpha(input int k); return k == 1; endfunction
  function automatic logic cfg_msb(input int k);  return k != 2; endfunction

  function automatic logic get_miso(input int k);
    return (k == 0) ? miso0 : (k == 1) ? miso1 : miso2;
  endfunction
  function automatic logic get_txr(input int k);
    return (k == 0) ? txr0 : (k == 1) ? txr1 : txr2;
  endfunction
  function automatic logic get_und(input int k);
    return (k == 0) ? und0 : (k == 1) ? und1 : und2;
  endfunction
  function automatic logic get_busy(input int k);
    return (k == 0) ? busy0 : (k == 1) ? busy1 : busy2;
  endfunction
  function automatic logic [31:0] get_rxd(input int k);
    return (k == 0) ? {24'h0, rxd0} : (k == 1) ? {24'h0, rxd1} : {16'h0, rxd2};
  endfunction
  function automatic int get_rxc(input int k);
    return (k == 0) ? rxc0 : (k == 1) ? rxc1 : rxc2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] d);
    int n;
    n = 0;
    while (!get_txr(k) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL push_wait: tx_ready stayed 0 for %0d clks, required 1", n);
    end
    @(negedge clk);
    case (k)
      0: txd0 = d[7:0];
      1: txd1 = d[7:0];
      default: txd2 = d[15:0];
    endcase
    txv_v[k] = 1'b1;
    @(negedge clk);
    txv_v[k] = 1'b0;
  endtask

  task automatic start(input int k);
    cs_v[k] = 1'b0;
    #HALF;
  endtask

  task automatic stop(input int k);
    #HALF;
    cs_v[k] = 1'b1;
    #(3*HALF);
  endtask

  task automatic bits(input int k, input int nb, input logic [31:0] mo, output logic [31:0] mi);
    logic cpol, cpha;
    cpol = cfg_cpol(k);
    cpha = cfg_cpha(k);
    mi = '0;
    for (int i = 0; i < nb; i++) begin
      int idx;
      idx = cfg_msb(k) ? cfg_w(k) - 1 - i : i;
      if (!cpha) begin
        mosi_v[k] = mo[idx];
        #HALF;
        mi[idx] = get_miso(k);
        sclk_v[k] = ~cpol;
        #HALF;
        sclk_v[k] = cpol;
      end else begin
        sclk_v[k] = ~cpol;
        mosi_v[k] = mo[idx];
        #HALF;
        mi[idx] = get_miso(k);
        sclk_v[k] = cpol;
        #HALF;
      end
    end
  endtask

  typedef struct {
    int          k;
    logic [31:0] tx;
    logic [31:0] mo;
    logic [31:0] exp_mi;
    logic [31:0] exp_rx;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [31:0] mi, mi2;
    int c;

    vecs[0] = '{0, 32'hA5,   32'h3C,   32'hA5,   32'h3C};
    vecs[1] = '{1, 32'hA5,   32'h3C,   32'hA5,   32'h3C};
    vecs[2] = '{0, 32'h0F,   32'hF0,   32'h0F,   32'hF0};
    vecs[3] = '{1, 32'h96,   32'h69,   32'h96,   32'h69};
    vecs[4] = '{2, 32'hBEEF, 32'h1234, 32'hBEEF, 32'h1234};
    vecs[5] = '{2, 32'h8001, 32'h0001, 32'h8001, 32'h0001};

    rst_n = 1'b0;
    cs_v = 3'b111; sclk_v = 3'b010; mosi_v = '0; txv_v = '0;
    txd0 = '0; txd1 = '0; txd2 = '0;
    repeat (3) @(negedge clk);
    check("rst_miso", {31'h0, miso0}, 32'h0);
    check("rst_tx_ready", {31'h0, txr0}, 32'h1);
    check("rst_rx_data", get_rxd(0), 32'h0);
    check("rst_rx_valid", {31'h0, rxv0}, 32'h0);
    check("rst_underrun", {31'h0, und0}, 32'h0);
    check("rst_busy", {29'h0, busy2, busy1, busy0}, 32'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      push(vecs[v].k, vecs[v].tx);
      check($sformatf("v%0d_tx_ready_full", v), {31'h0, get_txr(vecs[v].k)}, 32'h0);
      c = get_rxc(vecs[v].k);
      start(vecs[v].k);
      check($sformatf("v%0d_busy", v), {31'h0, get_busy(vecs[v].k)}, 32'h1);
      bits(vecs[v].k, cfg_w(vecs[v].k), vecs[v].mo, mi);
      stop(vecs[v].k);
      check($sformatf("v%0d_miso", v), mi, vecs[v].exp_mi);
      check($sformatf("v%0d_rx_data", v), get_rxd(vecs[v].k), vecs[v].exp_rx);
      check($sformatf("v%0d_rx_pulses", v), 32'(get_rxc(vecs[v].k) - c), 32'd1);
      check($sformatf("v%0d_underrun", v), {31'h0, get_und(vecs[v].k)}, 32'h0);
      check($sformatf("v%0d_idle", v), {30'h0, get_busy(vecs[v].k), get_miso(vecs[v].k)}, 32'h0);
    end

    // back-to-back words, second tx word accepted during the first
    push(0, 32'hA5);
    c = rxc0;
    start(0);
    fork
      begin
        bits(0, 8, 32'h3C, mi);
        bits(0, 8, 32'hC3, mi2);
      end
      begin
        #(HALF*6);
        push(0, 32'h5A);
      end
    join
    stop(0);
    check("b2b_miso_w1", mi, 32'hA5);
    check("b2b_miso_w2", mi2, 32'h5A);
    check("b2b_rx_pulses", 32'(rxc0 - c), 32'd2);
    check("b2b_rx_data", get_rxd(0), 32'hC3);
    check("b2b_underrun", {31'h0, und0}, 32'h0);

    // cs released after 3 bits, then a full word
    push(0, 32'hC3);
    c = rxc0;
    start(0);
    bits(0, 3, 32'hFF, mi);
    stop(0);
    check("part_no_rx_valid", 32'(rxc0 - c), 32'd0);
    check("part_idle", {30'h0, busy0, miso0}, 32'h0);
    check("part_rx_data_kept", get_rxd(0), 32'hC3);
    push(0, 32'h7E);
    start(0);
    bits(0, 8, 32'h81, mi);
    stop(0);
    check("after_part_rx", get_rxd(0), 32'h81);
    check("after_part_miso", mi, 32'h7E);
    check("after_part_pulses", 32'(rxc0 - c), 32'd1);

    // underrun: nothing buffered
    start(0);
    bits(0, 8, 32'h00, mi);
    stop(0);
    check("undr_miso", mi, 32'hFF);
    check("undr_flag", {31'h0, und0}, 32'h1);
    check("undr_rx", get_rxd(0), 32'h00);
    push(0, 32'h12);
    start(0);
    bits(0, 8, 32'h34, mi);
    stop(0);
    check("undr_sticky", {31'h0, und0}, 32'h1);
    check("undr_next_miso", mi, 32'h12);

    // reset mid-word with cs held low
    push(0, 32'h11);
    start(0);
    push(0, 32'h22);
    bits(0, 3, 32'hAA, mi);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy", {31'h0, busy0}, 32'h0);
    check("midrst_tx_ready", {31'h0, txr0}, 32'h1);
    check("midrst_rx_data", get_rxd(0), 32'h0);
    check("midrst_underrun", {31'h0, und0}, 32'h0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_reentry", {31'h0, busy0}, 32'h0);
    check("midrst_miso", {31'h0, miso0}, 32'h0);
    cs_v[0] = 1'b1;
    sclk_v[0] = 1'b0;
    #(3*HALF);
    c = rxc0;
    push(0, 32'h42);
    start(0);
    bits(0, 8, 32'h99, mi);
    stop(0);
    check("postrst_rx", get_rxd(0), 32'h99);
    check("postrst_miso", mi, 32'h42);
    check("postrst_pulses", 32'(rxc0 - c), 32'd1);
    check("postrst_underrun", {31'h0, und0}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning bits per SPI word (legal 4..32).
REQ-002 The block SHALL have parameter CPOL, default 0, meaning sclk idle level.
REQ-003 The block SHALL have parameter CPHA, default 0, meaning 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = MSB shifted first, 0 = LSB first.
REQ-005 The block SHALL have parameter IDLE_TX, default all-ones, meaning the word sent when no tx word is buffered.
REQ-006 The block SHALL have port clk, input, 1 bit: system clock; single clock domain.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port cs, input, 1 bit: chip select, active-low, asynchronous to clk.
REQ-009 The block SHALL have port sclk, input, 1 bit: SPI clock, asynchronous to clk.
REQ-010 The block SHALL have port mosi, input, 1 bit: master-out data.
REQ-011 The block SHALL have port miso, output, 1 bit: slave-out data, registered on clk.
REQ-012 The block SHALL have port tx_data, input, DATA_W bits: next word to transmit.
REQ-013 The block SHALL have port tx_valid, input, 1 bit: tx_data valid.
REQ-014 The block SHALL have port tx_ready, output, 1 bit: tx holding buffer empty.
REQ-015 The block SHALL have port rx_data, output, DATA_W bits: last received word.
REQ-016 The block SHALL have port rx_valid, output, 1 bit: one-clk pulse per received word.
REQ-017 The block SHALL have port tx_underrun, output, 1 bit: sticky; a word started with the holding buffer empty.
REQ-018 The block SHALL have port busy, output, 1 bit: transaction active.

Function
REQ-019 cs, sclk and mosi SHALL pass through 2-flop synchronisers; all edge detection SHALL use synchronised values; sclk period SHALL be >= 8 clk periods.
REQ-020 The FSM SHALL have states IDLE, ACTIVE; IDLE->ACTIVE on synchronised cs falling; any state->IDLE on synchronised cs high.
REQ-021 On IDLE->ACTIVE, the shift register SHALL load the holding buffer (buffer freed, tx_ready=1 next clk) or IDLE_TX if empty; bit counter SHALL clear.
REQ-022 With CPHA=0, the first bit SHALL appear on miso within 1 clk of ACTIVE entry; later bits SHALL update on each trailing edge.
REQ-023 With CPHA=1, miso SHALL update on each leading edge, including the first.
REQ-024 Leading edge SHALL be the sclk transition away from CPOL; trailing edge SHALL be the transition back.
REQ-025 mosi SHALL be sampled on the sample edge into the rx shifter in MSB_FIRST order; bit counter SHALL increment per sample.
REQ-026 After DATA_W samples, rx_data SHALL update and rx_valid SHALL pulse 1 clk on the following clk; counter SHALL wrap to 0 and the next tx word SHALL load as in REQ-021 (back-to-back words without cs release).
REQ-027 tx_valid && tx_ready SHALL capture tx_data into the 1-entry buffer; tx_ready SHALL drop the next clk; tx_data SHALL be ignored while tx_ready=0.
REQ-028 A load with an empty buffer SHALL set tx_underrun; it SHALL clear only on reset.
REQ-029 A buffer load and a tx accept in the same clk SHALL take the buffered word, then store the new one (tx_ready stays 0).
REQ-030 cs rising mid-word SHALL discard the partial rx word (no rx_valid), drive miso 0, and leave the buffer intact.
REQ-031 miso SHALL be 0 in IDLE; busy SHALL equal (state==ACTIVE).

Reset
REQ-032 During rst_n=0: state IDLE, miso 0, tx_ready 1, rx_data 0, rx_valid 0, tx_underrun 0, busy 0, buffer empty, synchronisers reset to cs=1, sclk=CPOL.
REQ-033 Reset mid-transaction SHALL abort the word; the block SHALL re-enter ACTIVE only on a fresh cs falling edge.

Structure
REQ-034 Package spi_pkg SHALL hold the FSM state typedef and mode constants (SPI_MODE0..3 as {CPOL,CPHA}).
REQ-035 Sub-module spi_sync (2-flop synchroniser, async active-low reset, parametrised reset value) SHALL be instantiated per async input.

Verification
REQ-036 Mode 0, DATA_W=8: tx 0xA5 buffered, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C, one rx_valid pulse.
REQ-037 Mode 3 (CPOL=1, CPHA=1): same stimulus -> identical data both directions.
REQ-038 Back-to-back 2 words, second tx 0x5A accepted mid-first-word -> miso 0xA5 then 0x5A; rx_valid pulses twice; tx_underrun 0.
REQ-039 No tx buffered: master sends 0x00 -> miso 0xFF; tx_underrun=1 until reset.
REQ-040 cs released after 3 bits -> no rx_valid; next full word 0x81 received correctly.
REQ-041 MSB_FIRST=0, DATA_W=16: master sends 0x1234 LSB-first -> rx_data=0x1234.
